lif_neuron_sequencer: RTL and testbench

Controller in front of the LIF neuron core. Serially loads decay/weight/threshold into the core over its set_vars/expd/w/t bit lines. Round-robin arbitrates up to N_REQ presynaptic spike requesters onto the core's single syn input. Counts output spikes seen on axon.

---
 rtl/lif_neuron_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_lif_neuron_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_sequencer.sv
// lif_neuron_sequencer
// Front-end controller for a LIF neuron core.
//   - Serially loads decay/weight/threshold bytes (MSB first, in parallel
//     on expd/w/t) while holding set_vars high for 8 cycles.
//   - Round-robin arbitrates N_REQ level spike requests onto the single syn
//     input; each grant produces a SYN_PULSE-cycle syn pulse plus a 1-cycle gap.
//   - Counts axon rising edges (saturating, cleared on config acceptance).
// Optional build macro: NEURON_SEQ_REFRACTORY_EN blocks new grants for
// REFRAC_CYC cycles after each axon rising edge.
// Ports:
//   clk, rst (async, active-low)
//   cfg_valid/cfg_ready + cfg_decay/cfg_weight/cfg_thresh : config handshake
//   spk_req/spk_grant   : spike requesters, one-hot one-cycle grant
//   set_vars/expd/w/t   : serial load lines to the core
//   syn                 : synaptic pulse to the core
//   axon                : core spike output
//   spike_cnt           : axon rising-edge count
//   busy                : high whenever not IDLE
module lif_neuron_sequencer #(
    parameter int N_REQ      = 4,
    parameter int SYN_PULSE  = 2,
    parameter int REFRAC_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [7:0]       cfg_decay,
    input  logic [7:0]       cfg_weight,
    input  logic [7:0]       cfg_thresh,
    input  logic [N_REQ-1:0] spk_req,
    output logic [N_REQ-1:0] spk_grant,
    output logic             set_vars,
    output logic             expd,
    output logic             w,
    output logic             t,
    output logic             syn,
    input  logic             axon,
    output logic [15:0]      spike_cnt,
    output logic             busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             set_vars_q, set_vars_d;
    logic             expd_q, expd_d, w_q, w_d, t_q, t_d;
    logic             syn_q, syn_d;
    // Remaining (not yet driven) bits of each byte; bit 6 is next out.
    logic [6:0]       dec_q, dec_d, wgt_q, wgt_d, thr_q, thr_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       pulse_cnt_q, pulse_cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             axon_d_q;
    logic [15:0]      spike_cnt_q, spike_cnt_d;

    logic             axon_rise;
    logic             grant_ok;
    logic             found;
    logic [PW-1:0]    win;

    assign axon_rise = axon & ~axon_d_q;

`ifdef NEURON_SEQ_REFRACTORY_EN
    localparam int RW = $clog2(REFRAC_CYC + 1);
    logic [RW-1:0] refrac_q, refrac_d;

    // Each edge (re)starts the window; grants resume once it drains to 0.
    always_comb begin
        refrac_d = refrac_q;
        if (axon_rise)
            refrac_d = RW'(REFRAC_CYC);
        else if (refrac_q != '0)
            refrac_d = refrac_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) refrac_q <= '0;
        else      refrac_q <= refrac_d;
    end

    assign grant_ok = (refrac_q == '0);
`else
    assign grant_ok = 1'b1;
`endif

    // Round-robin search starting at ptr_q, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && spk_req[(int'(ptr_q) + k) % N_REQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = '0;
        set_vars_d  = set_vars_q;
        expd_d      = expd_q;
        w_d         = w_q;
        t_d         = t_q;
        syn_d       = syn_q;
        dec_d       = dec_q;
        wgt_d       = wgt_q;
        thr_d       = thr_q;
        bit_cnt_d   = bit_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        ptr_d       = ptr_q;
        spike_cnt_d = spike_cnt_q;

        if (axon_rise && spike_cnt_q != 16'hFFFF)
            spike_cnt_d = spike_cnt_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    // Bit 7 goes out on the acceptance edge; the rest shift.
                    state_d     = S_LOAD;
                    set_vars_d  = 1'b1;
                    expd_d      = cfg_decay[7];
                    w_d         = cfg_weight[7];
                    t_d         = cfg_thresh[7];
                    dec_d       = cfg_decay[6:0];
                    wgt_d       = cfg_weight[6:0];
                    thr_d       = cfg_thresh[6:0];
                    bit_cnt_d   = 3'd0;
                    spike_cnt_d = 16'd0;  // overrides a same-cycle edge
                end else if (found && grant_ok) begin
                    state_d      = S_PULSE;
                    grant_d[win] = 1'b1;
                    syn_d        = 1'b1;
                    pulse_cnt_d  = 4'(SYN_PULSE - 1);
                    ptr_d        = PW'((int'(win) + 1) % N_REQ);
                end
            end
            S_LOAD: begin
                if (bit_cnt_q == 3'd7) begin
                    state_d    = S_IDLE;
                    set_vars_d = 1'b0;
                    expd_d     = 1'b0;
                    w_d        = 1'b0;
                    t_d        = 1'b0;
                end else begin
                    expd_d    = dec_q[6];
                    w_d       = wgt_q[6];
                    t_d       = thr_q[6];
                    dec_d     = {dec_q[5:0], 1'b0};
                    wgt_d     = {wgt_q[5:0], 1'b0};
                    thr_d     = {thr_q[5:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_PULSE: begin
                if (pulse_cnt_q == 4'd0) begin
                    state_d = S_GAP;
                    syn_d   = 1'b0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;  // S_GAP: one syn-low cycle
        endcase

        cfg_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            grant_q     <= '0;
            set_vars_q  <= 1'b0;
            expd_q      <= 1'b0;
            w_q         <= 1'b0;
            t_q         <= 1'b0;
            syn_q       <= 1'b0;
            dec_q       <= '0;
            wgt_q       <= '0;
            thr_q       <= '0;
            bit_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            ptr_q       <= '0;
            axon_d_q    <= 1'b0;
            spike_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
            set_vars_q  <= set_vars_d;
            expd_q      <= expd_d;
            w_q         <= w_d;
            t_q         <= t_d;
            syn_q       <= syn_d;
            dec_q       <= dec_d;
            wgt_q       <= wgt_d;
            thr_q       <= thr_d;
            bit_cnt_q   <= bit_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            ptr_q       <= ptr_d;
            axon_d_q    <= axon;
            spike_cnt_q <= spike_cnt_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign spk_grant = grant_q;
    assign set_vars  = set_vars_q;
    assign expd      = expd_q;
    assign w         = w_q;
    assign t         = t_q;
    assign syn       = syn_q;
    assign spike_cnt = spike_cnt_q;

endmodule

// File: tb/tb_lif_neuron_sequencer.sv
// Directed bench for lif_neuron_sequencer (N_REQ=4, SYN_PULSE=2, REFRAC_CYC=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lif_neuron_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_decay = 8'h00, cfg_weight = 8'h00, cfg_thresh = 8'h00;
    logic [3:0]  spk_req = 4'h0;
    logic [3:0]  spk_grant;
    logic        set_vars, expd, w, t, syn;
    logic        axon = 1'b0;
    logic [15:0] spike_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef NEURON_SEQ_REFRACTORY_EN
    localparam int GRANT_K = 5;
`else
    localparam int GRANT_K = 1;
`endif

    lif_neuron_sequencer #(.N_REQ(4), .SYN_PULSE(2), .REFRAC_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_decay(cfg_decay), .cfg_weight(cfg_weight), .cfg_thresh(cfg_thresh),
        .spk_req(spk_req), .spk_grant(spk_grant),
        .set_vars(set_vars), .expd(expd), .w(w), .t(t), .syn(syn),
        .axon(axon), .spike_cnt(spike_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] dv, wv, tv;
        logic [3:0] eg;

        // reset held two cycles
        tick(); tick();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grant", spk_grant, 0);
        chk("rst_lines", {set_vars, expd, w, t, syn}, 0);
        chk("rst_cnt", spike_cnt, 0);
        rst = 1'b1;
        tick();

        // serial config load
        dv = 8'h0F; wv = 8'hA5; tv = 8'h80;
        cfg_decay = dv; cfg_weight = wv; cfg_thresh = tv; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_ready", cfg_ready, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("load_sv%0d", i), set_vars, 1);
            chk($sformatf("load_bits%0d", i), {expd, w, t}, {dv[7-i], wv[7-i], tv[7-i]});
            tick();
        end
        chk("load_end_sv", set_vars, 0);
        chk("load_end_bits", {expd, w, t}, 0);
        chk("load_end_ready", cfg_ready, 1);

        // round-robin with all requesters held
        spk_req = 4'hF;
        tick();
        for (int c = 0; c < 20; c++) begin
            eg = ((c % 4) == 0) ? (4'b0001 << ((c / 4) % 4)) : 4'b0000;
            chk($sformatf("rr_grant%0d", c), spk_grant, eg);
            chk($sformatf("rr_syn%0d", c), syn, ((c % 4) < 2) ? 1 : 0);
            if (c == 19) spk_req = 4'h0;
            tick();
        end
        chk("rr_idle_grant", spk_grant, 0);
        chk("rr_idle_busy", busy, 0);

        // cfg wins over a same-cycle request, request pends through LOAD
        cfg_decay = 8'h3C; cfg_valid = 1'b1; spk_req = 4'b0100;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pend_grant%0d", i), spk_grant, 0);
            chk($sformatf("pend_sv%0d", i), set_vars, 1);
            tick();
        end
        chk("pend_idle_grant", spk_grant, 0);
        chk("pend_idle_ready", cfg_ready, 1);
        tick();
        chk("pend_grant2", spk_grant, 4'b0100);
        chk("pend_syn", syn, 1);
        spk_req = 4'h0;
        tick(); tick(); tick();
        chk("pend_back_idle", busy, 0);

        // axon edge then request: refractory delays the grant when enabled
        axon = 1'b1;
        tick();
        axon = 1'b0; spk_req = 4'b0010;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("refr_grant%0d", k), spk_grant, (k == GRANT_K) ? 4'b0010 : 4'b0000);
            if (k == GRANT_K) spk_req = 4'h0;
        end
        tick(); tick(); tick(); tick();
        chk("refr_cnt", spike_cnt, 1);

        // edge counting: three pulses, then a long high counts once
        for (int p = 0; p < 3; p++) begin
            axon = 1'b1; tick(); axon = 1'b0; tick();
        end
        chk("cnt_after3", spike_cnt, 4);
        axon = 1'b1; tick(); tick(); tick(); axon = 1'b0; tick();
        chk("cnt_long_high", spike_cnt, 5);

        // config clears count; a simultaneous edge is lost; LOAD still counts
        cfg_valid = 1'b1; axon = 1'b1;
        tick();
        cfg_valid = 1'b0; axon = 1'b0;
        chk("cnt_cleared", spike_cnt, 0);
        tick();
        axon = 1'b1;
        tick();
        axon = 1'b0;
        chk("cnt_in_load", spike_cnt, 1);
        chk("cnt_in_load_sv", set_vars, 1);
        for (int i = 0; i < 7; i++) tick();
        chk("cnt_load_done", cfg_ready, 1);

        // saturation from a preloaded count
        force dut.spike_cnt_q = 16'hFFFD;
        tick();
        release dut.spike_cnt_q;
        chk("sat_pre", spike_cnt, 16'hFFFD);
        axon = 1'b1; tick(); axon = 1'b0; tick();
        chk("sat_fffe", spike_cnt, 16'hFFFE);
        axon = 1'b1; tick(); axon = 1'b0; tick();
        chk("sat_ffff", spike_cnt, 16'hFFFF);
        axon = 1'b1; tick(); axon = 1'b0; tick();
        chk("sat_hold", spike_cnt, 16'hFFFF);

        // asynchronous reset mid-pulse
        spk_req = 4'b0001;
        tick();
        chk("mid_syn", syn, 1);
        rst = 1'b0;
        #1;
        chk("arst_syn", syn, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", cfg_ready, 1);
        chk("arst_grant", spk_grant, 0);
        chk("arst_cnt", spike_cnt, 0);
        spk_req = 4'h0;
        tick();
        rst = 1'b1;
        // pointer back at 0: requester 0 beats requester 3
        spk_req = 4'b1001;
        tick();
        chk("arst_ptr", spk_grant, 4'b0001);
        spk_req = 4'h0;
        tick(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
